// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for the CONV input-SRAM read path.
//   WORD_AMOUNT / BIT_PER_WORD / ADDR_W : default SRAM geometry
//   PIX_W / PIX_N                        : pixel width and pixels per word
//   rd_state_t                           : read sequencer FSM states
package conv_pkg;
    localparam int WORD_AMOUNT  = 3136;
    localparam int BIT_PER_WORD = 145;
    localparam int ADDR_W       = $clog2(WORD_AMOUNT);
    localparam int PIX_W        = 16;
    localparam int PIX_N        = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;
endpackage

// File: rtl/sram_rd_fifo.sv
// sram_rd_fifo: small synchronous FIFO holding SRAM words plus their last tag.
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata     : write strobe and data; a push into a full FIFO is dropped
//                     unless a pop happens in the same cycle
//   pop, rdata      : read strobe and head-of-queue data (show-ahead)
//   empty, count    : status / occupancy
module sram_rd_fifo
    import conv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = BIT_PER_WORD + 1,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            if (do_pop)  rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/sram_i_reader.sv
// sram_i_reader: streams every word of the input-feature SRAM to the PE array.
//   clk, rst          : clock, synchronous active-high reset
//   start             : frame start pulse, only honoured while idle
//   sram_addr/sram_we : SRAM read address (registered), write enable tied low
//   sram_dout         : SRAM read data, one cycle after the address
//   m_valid/m_ready   : output stream handshake
//   m_pix/m_flag      : nine 16-bit pixels and the tile flag (word bit 144)
//   m_last            : marks the word read from address WORD_AMOUNT-1
//   busy/done         : frame in progress / one-cycle completion pulse
//   perf_stall_cnt    : cycles with m_valid && !m_ready (needs SRAM_RD_PERF_EN,
//                       otherwise constant 0)
module sram_i_reader #(
    parameter int  WORD_AMOUNT  = conv_pkg::WORD_AMOUNT,
    parameter int  BIT_PER_WORD = conv_pkg::BIT_PER_WORD,
    parameter int  FIFO_DEPTH   = 4,
    localparam int AW           = $clog2(WORD_AMOUNT),
    localparam int PIXB         = conv_pkg::PIX_W * conv_pkg::PIX_N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [AW-1:0]           sram_addr,
    output logic                    sram_we,
    input  logic [BIT_PER_WORD-1:0] sram_dout,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [PIXB-1:0]         m_pix,
    output logic                    m_flag,
    output logic                    m_last,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             perf_stall_cnt
);
    import conv_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = BIT_PER_WORD + 1;

    rd_state_t       state;
    logic [AW-1:0]   addr_q;
    logic            rd_vld;    // SRAM data for an issued read is on sram_dout
    logic            rd_last;   // last tag travelling with that read
    logic            issue;
    logic            at_last;
    logic            pop;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_cnt;
    logic [FW-1:0]   fifo_rdata;

    assign at_last = (addr_q == AW'(WORD_AMOUNT - 1));

    // Credit check: every word already buffered or still coming back from
    // the SRAM owns a FIFO slot, so a new read never overruns the FIFO even
    // if the consumer stalls forever. Pops in this cycle are not credited,
    // which costs nothing at full rate.
    assign issue = (state == RUN) &&
                   ((int'(fifo_cnt) + int'(rd_vld)) < FIFO_DEPTH);

    assign pop = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done    <= 1'b0;
            rd_vld  <= issue;
            rd_last <= issue && at_last;
            case (state)
                IDLE: begin
                    addr_q <= '0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (at_last) state  <= DRAIN;
                        else         addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // The last-tagged word is the final one issued, so once it
                    // leaves the FIFO nothing else is buffered or in flight.
                    if (pop && fifo_rdata[FW-1]) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        addr_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_vld),
        .wdata ({rd_last, sram_dout}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign sram_addr = addr_q;
    assign sram_we   = 1'b0;
    assign m_valid   = !fifo_empty;
    // Payload is zeroed while nothing is valid so it reads 0 out of reset.
    assign m_pix     = m_valid ? fifo_rdata[PIXB-1:0] : '0;
    assign m_flag    = m_valid && fifo_rdata[BIT_PER_WORD-1];
    assign m_last    = m_valid && fifo_rdata[FW-1];

`ifdef SRAM_RD_PERF_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (state == IDLE && start)
            stall_q <= '0;
        else if (m_valid && !m_ready && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 1'b1;
    end
    assign perf_stall_cnt = stall_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: doc/sram_i_reader.md
# sram_i_reader

Streaming read sequencer for the 3136 × 145-bit input-feature SRAM of the CONV datapath. On a start pulse it sweeps every SRAM address in order, absorbs the SRAM's one-cycle registered read latency, and presents each word to the downstream convolution PE array as a valid/ready stream. Credit-based issue and a small output FIFO make backpressure lossless. Sits between the input SRAM (it drives `addr` and consumes `dout`) and the PE array.

## Interface
- `WORD_AMOUNT`, default 3136, number of words swept per frame.
- `BIT_PER_WORD`, default 145, SRAM word width; bit 144 is the tile flag, bits 143:0 hold nine 16-bit pixels.
- `FIFO_DEPTH`, default 4, output FIFO entries; must be ≥ 3.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle frame start; ignored unless idle.
- `sram_addr`  out  $clog2(WORD_AMOUNT)  registered read address to the SRAM.
- `sram_we`  out  1  tied 0; the reader never writes.
- `sram_dout`  in  BIT_PER_WORD  SRAM read data, valid the cycle after the address is presented.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_pix`  out  144  nine 16-bit pixels, pixel k at [16k+15:16k].
- `m_flag`  out  1  bit 144 of the word.
- `m_last`  out  1  high with the word from address WORD_AMOUNT-1.
- `busy`  out  1  high from the start edge until `done`.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `perf_stall_cnt`  out  32  backpressure stall counter (see Configuration).

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE → RUN on `start`. The address counter clears to 0 and `busy` rises.
- RUN: issue one read per cycle while (FIFO occupancy + reads in flight) < FIFO_DEPTH. A read is in flight from issue until its data is written to the FIFO, which takes 2 cycles. After the read of address WORD_AMOUNT-1 is issued, go to DRAIN.
- DRAIN: issue no reads. Once the FIFO is empty, nothing is in flight, and the last handshake has completed, pulse `done`, drop `busy`, and go to IDLE.
- A handshake completes when `m_valid && m_ready`. It pops the FIFO. `m_pix`, `m_flag` and `m_last` are stable while `m_valid` is high and `m_ready` is low.
- Each word's `m_last` bit is tagged at issue time and travels with the word through the pipeline.
- Address counter: increments by 1 per issued read, no wrap inside a frame, returns to 0 in IDLE.
- `start` while `busy` is ignored and has no side effect.
- Reset (including mid-frame): state → IDLE, FIFO emptied, in-flight tags cleared, the SRAM data still returning is discarded, and `done` is not pulsed.
- Reset values: `sram_addr`=0, `sram_we`=0, `m_valid`=0, `m_last`=0, `busy`=0, `done`=0, `perf_stall_cnt`=0. `m_pix` and `m_flag` reset to 0.

## Timing
- `start` is sampled at edge E0. `sram_addr`=0 from E0. SRAM data is captured at E1 and written to the FIFO at E2. `m_valid` rises after E2, giving a start-to-first-valid latency of 3 cycles.
- With `m_ready` held at 1, throughput is 1 word/cycle and no bubbles occur after the first word.
- A full frame with `m_ready`=1 completes in WORD_AMOUNT+3 cycles from start to `done`. `done` is asserted in the cycle after the last handshake.
- When `m_ready` drops, issue stops within the credit limit and no word is lost or duplicated. When `m_ready` returns, the output resumes the next cycle from the FIFO head.
- A FIFO push and pop in the same cycle is legal and leaves occupancy unchanged.

## Configuration
- Macro: `SRAM_RD_PERF_EN`.
- Defined: `perf_stall_cnt` increments on every cycle with `m_valid && !m_ready`. It saturates at 2^32-1, clears on `start` accepted in IDLE and on reset, and holds its value in IDLE.
- Undefined: `perf_stall_cnt` is constant 0 and the counter logic is absent.

## Structure
- Shared package `conv_pkg`:
  - `WORD_AMOUNT`, `BIT_PER_WORD` and `ADDR_W = $clog2(WORD_AMOUNT)`.
  - Pixel width 16 and pixel count 9.
  - FSM state enum `rd_state_t`.
- One sub-module, `sram_rd_fifo`: synchronous FIFO, FIFO_DEPTH × (BIT_PER_WORD+1) bits (word plus last tag). It exposes occupancy, and its reset is synchronous on `rst`.

## Test plan
- Memory preloaded with word[a] = {a[0], nine copies of a[15:0]}, `start`, `m_ready`=1 → 3136 words in address order, first `m_valid` exactly 3 cycles after start, `m_last` only on a=3135, `done` at cycle 3139.
- Random `m_ready` (50%) → all 3136 words accepted exactly once and in order, FIFO never overflows, and with `SRAM_RD_PERF_EN` `perf_stall_cnt` equals the count of stalled-valid cycles.
- `m_ready`=0 for 20 cycles after start → at most FIFO_DEPTH reads issued, output stable, and the stream resumes correctly afterwards.
- `start` pulsed again at word 100 → ignored, frame still ends at a=3135 with a single `done`.
- `rst` asserted at word 1500 for 1 cycle → all outputs at reset values next cycle and no `done`. A new `start` then delivers word 0 first.
